// File: rtl/deadlock_param_monitor_if.sv
// Monitor handshake bundle: enable/clear, blocked/idle flag vectors in, sticky verdict out.
// Slave modport faces the monitor, master modport faces whatever drives and observes it.
interface deadlock_param_monitor_if #(
  parameter int N_AXIS = 2,
  parameter int N_INST = 5,
  parameter int N_BLK  = 1,
  parameter int CNT_W  = 16
);
  logic              i_enable;
  logic              i_clear;
  logic [N_AXIS-1:0] i_axis_block_sigs;
  logic [N_INST-1:0] i_inst_idle_sigs;
  logic [N_BLK-1:0]  i_inst_block_sigs;
  logic              o_block;
  logic              o_block_pulse;
  logic [CNT_W-1:0]  o_stall_cnt;
  logic [N_AXIS-1:0] o_cause_axis;
  logic [N_BLK-1:0]  o_cause_inst;
  logic [1:0]        o_mon_state;

  modport slave (
    input  i_enable, i_clear, i_axis_block_sigs, i_inst_idle_sigs, i_inst_block_sigs,
    output o_block, o_block_pulse, o_stall_cnt, o_cause_axis, o_cause_inst, o_mon_state
  );

  modport master (
    output i_enable, i_clear, i_axis_block_sigs, i_inst_idle_sigs, i_inst_block_sigs,
    input  o_block, o_block_pulse, o_stall_cnt, o_cause_axis, o_cause_inst, o_mon_state
  );
endinterface

// File: rtl/deadlock_param_monitor.sv
// Declares deadlock once the blocked-flag vector stays unchanged for HOLD_CYCLES cycles.
// Verdict registered on the HOLD_CYCLES-th stable edge; purely observational, exerts no backpressure.
module deadlock_param_monitor #(
  parameter int N_AXIS      = 2,
  parameter int N_INST      = 5,
  parameter int N_BLK       = 1,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 16
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  deadlock_param_monitor_if.slave mon
);
  localparam int VEC_W = N_AXIS + N_BLK;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] HOLD    = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ARMED    = 2'd1,
    S_DEADLOCK = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_block;
  logic              r_block_pulse;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [VEC_W-1:0]  r_snap;
  logic [N_AXIS-1:0] r_cause_axis;
  logic [N_BLK-1:0]  r_cause_inst;

  logic [VEC_W-1:0]  w_vec;
  logic              w_cand;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_enter;

  assign w_vec     = {mon.i_inst_block_sigs, mon.i_axis_block_sigs};
  assign w_cand    = mon.i_enable & (|w_vec) & ~(&mon.i_inst_idle_sigs);
  assign w_cnt_inc = (r_stall_cnt == CNT_MAX) ? r_stall_cnt : r_stall_cnt + CNT_ONE;

  // Entry fires either straight from IDLE (single-cycle hold) or when the stable count reaches the hold.
  assign w_enter = w_cand &&
                   (((r_state == S_IDLE) && (HOLD_CYCLES == 1)) ||
                    ((r_state == S_ARMED) && (w_vec == r_snap) && (w_cnt_inc == HOLD)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_block       <= 1'b0;
      r_block_pulse <= 1'b0;
      r_stall_cnt   <= '0;
      r_snap        <= '0;
      r_cause_axis  <= '0;
      r_cause_inst  <= '0;
    end else begin
      r_block_pulse <= 1'b0;
      if (mon.i_clear) begin
        r_state      <= S_IDLE;
        r_block      <= 1'b0;
        r_stall_cnt  <= '0;
        r_snap       <= '0;
        r_cause_axis <= '0;
        r_cause_inst <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_cand) begin
              r_snap      <= w_vec;
              r_stall_cnt <= CNT_ONE;
              r_state     <= S_ARMED;
            end else begin
              r_stall_cnt <= '0;
            end
          end
          S_ARMED: begin
            if (!w_cand) begin
              r_state     <= S_IDLE;
              r_stall_cnt <= '0;
              r_snap      <= '0;
            end else if (w_vec != r_snap) begin
              r_snap      <= w_vec;
              r_stall_cnt <= CNT_ONE;
            end else begin
              r_stall_cnt <= w_cnt_inc;
            end
          end
          S_DEADLOCK: r_stall_cnt <= w_cnt_inc;
          default: begin
            r_state     <= S_IDLE;
            r_stall_cnt <= '0;
            r_snap      <= '0;
          end
        endcase
        if (w_enter) begin
          r_state       <= S_DEADLOCK;
          r_block       <= 1'b1;
          r_block_pulse <= 1'b1;
          r_cause_axis  <= mon.i_axis_block_sigs;
          r_cause_inst  <= mon.i_inst_block_sigs;
        end
      end
    end
  end

  assign mon.o_block       = r_block;
  assign mon.o_block_pulse = r_block_pulse;
  assign mon.o_stall_cnt   = r_stall_cnt;
  assign mon.o_cause_axis  = r_cause_axis;
  assign mon.o_cause_inst  = r_cause_inst;
  assign mon.o_mon_state   = r_state;
endmodule

// File: doc/deadlock_param_monitor.md
DEADLOCK_PARAM_MONITOR -- requirements
Module: deadlock_param_monitor

Interface
REQ-001 SHALL have parameter N_AXIS, default 2, number of AXI-stream block inputs (>=1).
REQ-002 SHALL have parameter N_INST, default 5, number of instance idle inputs (>=1).
REQ-003 SHALL have parameter N_BLK, default 1, number of instance block inputs (>=1).
REQ-004 SHALL have parameter HOLD_CYCLES, default 16, consecutive stable blocked cycles required to declare deadlock (1..2^CNT_W-1).
REQ-005 SHALL have parameter CNT_W, default 16, stall counter width.
REQ-006 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-008 SHALL have port enable  input  1  monitoring enable; low forces the candidate condition false.
REQ-009 SHALL have port clear  input  1  synchronous clear of sticky deadlock and counters.
REQ-010 SHALL have port axis_block_sigs  input  N_AXIS  per-stream blocked flag.
REQ-011 SHALL have port inst_idle_sigs  input  N_INST  per-instance idle flag.
REQ-012 SHALL have port inst_block_sigs  input  N_BLK  per-instance blocked flag.
REQ-013 SHALL have port block  output  1  sticky deadlock flag.
REQ-014 SHALL have port block_pulse  output  1  one-cycle strobe on deadlock entry.
REQ-015 SHALL have port stall_cnt  output  CNT_W  current stable-stall count, saturating.
REQ-016 SHALL have port cause_axis  output  N_AXIS  axis_block_sigs snapshot latched at deadlock entry.
REQ-017 SHALL have port cause_inst  output  N_BLK  inst_block_sigs snapshot latched at deadlock entry.
REQ-018 SHALL have port mon_state  output  2  FSM state: 0 IDLE, 1 ARMED, 2 DEADLOCK.

Function
REQ-019 SHALL define vec = {inst_block_sigs, axis_block_sigs} and cand = enable & (|vec) & ~(&inst_idle_sigs), all combinational from current inputs.
REQ-020 SHALL hold a registered snapshot snap of vec, width N_AXIS+N_BLK.
REQ-021 IDLE: cand=1 -> snap<=vec, stall_cnt<=1, next ARMED (or DEADLOCK same edge if HOLD_CYCLES==1); cand=0 -> stay, stall_cnt<=0.
REQ-022 ARMED: cand=0 -> IDLE, stall_cnt<=0, snap<=0.
REQ-023 ARMED: cand=1 and vec!=snap (progress) -> stay ARMED, snap<=vec, stall_cnt<=1.
REQ-024 ARMED: cand=1 and vec==snap -> stall_cnt<=stall_cnt+1; when that new value equals HOLD_CYCLES -> DEADLOCK.
REQ-025 Deadlock entry edge: block<=1, block_pulse<=1 for exactly one cycle, cause_axis/cause_inst<=current vec fields.
REQ-026 DEADLOCK: sticky regardless of inputs and enable; stall_cnt keeps incrementing each cycle, saturating at 2^CNT_W-1, never wrapping; causes held.
REQ-027 clear=1 SHALL take priority over every transition: next IDLE, block<=0, block_pulse<=0, stall_cnt<=0, snap<=0, causes<=0, inputs that cycle ignored.
REQ-028 Latency: block SHALL rise on the edge closing the HOLD_CYCLES-th consecutive cycle with cand=1 and identical vec.
REQ-029 Any single cycle with cand=0 SHALL fully restart the count; no partial credit.
REQ-030 mon_state SHALL equal the registered FSM state; code 3 unused and SHALL recover to IDLE next edge.

Reset
REQ-031 reset low SHALL asynchronously force IDLE, block=0, block_pulse=0, stall_cnt=0, snap=0, cause_axis=0, cause_inst=0.
REQ-032 Reset asserted mid-ARMED or mid-DEADLOCK SHALL discard all progress; after release counting restarts from IDLE on the first rising edge.

Verification (N_AXIS=2, N_BLK=1, N_INST=5, HOLD_CYCLES=4)
REQ-033 idle=5'b00001, axis=2'b01 held 4 cycles, enable=1 -> block rises at the 4th edge, block_pulse 1 cycle, cause_axis=2'b01, cause_inst=0, mon_state=2.
REQ-034 axis=2'b01 for 3 cycles then 2'b10 for 3 cycles -> stall_cnt 1,2,3,1,2,3, block stays 0.
REQ-035 axis=2'b01 for 2 cycles, 1 cycle axis=0, then 2'b01 again -> stall_cnt 1,2,0,1; block only after 4 further stable cycles.
REQ-036 in DEADLOCK drive clear=1 with axis=2'b11 -> next edge block=0, stall_cnt=0, causes=0, mon_state=0.
REQ-037 idle=5'b11111 with axis=2'b11, or enable=0 -> stall_cnt stays 0, no deadlock; reset low mid-ARMED (stall_cnt=3) -> immediately all outputs 0.
